// File: rtl/tdes_ctrl_if.sv
// Request, core and result signal bundle for the triple-DES sequencing controller.
// Every handshake here is valid/ready: a transfer happens on a rising edge where both are high,
// and the valid side holds its payload stable until that edge.
interface tdes_ctrl_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [63:0] req_data_in;
  logic [63:0] req_key1_in;
  logic [63:0] req_key2_in;
  logic [63:0] req_key3_in;
  logic        req_mode_in;
  logic        req_verify_in;

  logic [63:0] core_data_out;
  logic [63:0] core_key_out;
  logic        core_mode_out;
  logic        core_verify_out;
  logic        core_valid_out;
  logic [63:0] core_result_in;
  logic        core_result_valid_in;
  logic        core_ready_in;
  logic        core_err_in;

  logic [63:0] res_data_out;
  logic [1:0]  res_err_out;
  logic        res_valid_out;
  logic        res_ready_in;

  modport slave (
    input  req_valid_in, req_data_in, req_key1_in, req_key2_in, req_key3_in,
           req_mode_in, req_verify_in,
           core_result_in, core_result_valid_in, core_ready_in, core_err_in,
           res_ready_in,
    output req_ready_out,
           core_data_out, core_key_out, core_mode_out, core_verify_out, core_valid_out,
           res_data_out, res_err_out, res_valid_out
  );

  modport master (
    output req_valid_in, req_data_in, req_key1_in, req_key2_in, req_key3_in,
           req_mode_in, req_verify_in,
           core_result_in, core_result_valid_in, core_ready_in, core_err_in,
           res_ready_in,
    input  req_ready_out,
           core_data_out, core_key_out, core_mode_out, core_verify_out, core_valid_out,
           res_data_out, res_err_out, res_valid_out
  );
endinterface

// File: rtl/tdes_ctrl.sv
// Sequences one single-DES core through the three EDE stages of a triple-DES request,
// with per-stage result timeout and core error abort.
module tdes_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  tdes_ctrl_if.slave  bus,
  output logic [1:0]  dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ERR_OK   = 2'b00;
  localparam logic [1:0]  ERR_CORE = 2'b01;
  localparam logic [1:0]  ERR_TMO  = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [15:0] tmo_q, tmo_d;
  logic [63:0] blk_q, blk_d;
  logic [63:0] key1_q, key1_d;
  logic [63:0] key2_q, key2_d;
  logic [63:0] key3_q, key3_d;
  logic        mode_q, mode_d;
  logic        verify_q, verify_d;
  logic [63:0] res_data_q, res_data_d;
  logic [1:0]  res_err_q, res_err_d;

  logic        req_ready;
  logic [63:0] key_sel;

  // Ready is held low during the reset cycle itself even though the state register reads IDLE.
  assign req_ready = (state_q == S_IDLE) && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      stage_q    <= 2'd0;
      tmo_q      <= 16'd0;
      blk_q      <= 64'd0;
      key1_q     <= 64'd0;
      key2_q     <= 64'd0;
      key3_q     <= 64'd0;
      mode_q     <= 1'b0;
      verify_q   <= 1'b0;
      res_data_q <= 64'd0;
      res_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      tmo_q      <= tmo_d;
      blk_q      <= blk_d;
      key1_q     <= key1_d;
      key2_q     <= key2_d;
      key3_q     <= key3_d;
      mode_q     <= mode_d;
      verify_q   <= verify_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    tmo_d      = tmo_q;
    blk_d      = blk_q;
    key1_d     = key1_q;
    key2_d     = key2_q;
    key3_d     = key3_q;
    mode_d     = mode_q;
    verify_d   = verify_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_in && req_ready) begin
          blk_d    = bus.req_data_in;
          key1_d   = bus.req_key1_in;
          key2_d   = bus.req_key2_in;
          key3_d   = bus.req_key3_in;
          mode_d   = bus.req_mode_in;
          verify_d = bus.req_verify_in;
          stage_d  = 2'd0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.core_ready_in) begin
          tmo_d   = 16'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        // A result on the final timeout cycle takes priority over the timeout.
        if (bus.core_result_valid_in) begin
          if (bus.core_err_in) begin
            res_data_d = 64'd0;
            res_err_d  = ERR_CORE;
            state_d    = S_DONE;
          end else begin
            blk_d = bus.core_result_in;
            if (stage_q == 2'd2) begin
              res_data_d = bus.core_result_in;
              res_err_d  = ERR_OK;
              state_d    = S_DONE;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = S_ISSUE;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          res_data_d = 64'd0;
          res_err_d  = ERR_TMO;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Encrypt runs K1,K2,K3 and decrypt runs K3,K2,K1; the middle stage always uses K2.
  always_comb begin
    key_sel = key2_q;
    if (stage_q == 2'd0)      key_sel = mode_q ? key3_q : key1_q;
    else if (stage_q == 2'd2) key_sel = mode_q ? key1_q : key3_q;
  end

  assign bus.req_ready_out   = req_ready;
  assign bus.core_data_out   = blk_q;
  assign bus.core_key_out    = key_sel;
  assign bus.core_mode_out   = mode_q ^ stage_q[0];
  assign bus.core_verify_out = verify_q;
  assign bus.core_valid_out  = (state_q == S_ISSUE);
  assign bus.res_valid_out   = (state_q == S_DONE);
  assign bus.res_data_out    = res_data_q;
  assign bus.res_err_out     = res_err_q;
  assign dbg_state_out       = state_q;

endmodule

// File: tb/tb_tdes_ctrl.sv
// Bench for tdes_ctrl: known-answer core model with an invertible stand-in cipher,
// core-port and result scoreboards, error, timeout, DONE-hold and mid-run reset scenarios.
module tb_tdes_ctrl;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [65:0]  exp_q[$];
  logic [129:0] exp_core_q[$];

  int core_fault = 0;
  int lat_fixed  = 0;
  int hs_cnt     = 0;
  int hs0_cyc    = 0;

  tdes_ctrl_if bus ();

  tdes_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .bus           (bus),
    .dbg_state_out (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [199:0] out_vec();
    return {1'b0, bus.req_ready_out, bus.core_valid_out, bus.core_mode_out, bus.core_verify_out,
            bus.res_valid_out, bus.res_err_out, bus.core_data_out, bus.core_key_out,
            bus.res_data_out};
  endfunction

  function automatic logic [199:0] reset_vec(input logic rdy);
    return {1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 192'd0};
  endfunction

  // ---------------- reference core ----------------
  // Known DES answers for the test key; elsewhere an invertible rotate/xor cipher.
  function automatic logic [63:0] core_fn(input logic dec, input logic [63:0] k, input logic [63:0] d);
    logic [63:0] x;
    if (k == KAT_KEY && !dec && d == KAT_PT) return KAT_CT;
    if (k == KAT_KEY &&  dec && d == KAT_CT) return KAT_PT;
    if (!dec) begin
      x = d ^ k;
      return {x[56:0], x[63:57]};
    end
    x = {d[6:0], d[63:7]};
    return x ^ k;
  endfunction

  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_res = '0;
  logic        pend_err = 1'b0;

  initial begin : core_model
    logic [129:0] obs;
    logic [129:0] exp;
    bus.core_result_valid_in = 1'b0;
    bus.core_err_in          = 1'b0;
    bus.core_ready_in        = 1'b0;
    bus.core_result_in       = '0;
    forever begin
      @(negedge clk);
      bus.core_result_valid_in = 1'b0;
      bus.core_err_in          = 1'b0;
      bus.core_result_in       = {$urandom, $urandom};
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.core_result_valid_in = 1'b1;
          bus.core_result_in       = pend_res;
          bus.core_err_in          = pend_err;
          pend                     = 1'b0;
        end
      end
      bus.core_ready_in = ($urandom_range(0, 3) != 0);
      if (bus.core_valid_out && bus.core_ready_in) begin
        hs_cnt++;
        if (hs_cnt == 1) hs0_cyc = cyc;
        obs = {bus.core_mode_out, bus.core_verify_out, bus.core_key_out, bus.core_data_out};
        chk("core_hs_expected", 200'(exp_core_q.size() != 0), 200'(1));
        if (exp_core_q.size() != 0) begin
          exp = exp_core_q.pop_front();
          chk("core_port", 200'(obs), 200'(exp));
        end
        if (core_fault != 2) begin
          pend     = 1'b1;
          pend_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
          pend_res = core_fn(bus.core_mode_out, bus.core_key_out, bus.core_data_out);
          pend_err = (core_fault == 1) && (hs_cnt == 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_core(input logic mode, input logic [63:0] d, k1, k2, k3, input logic ver,
                           input int n, output logic [63:0] fin);
    logic [63:0] x;
    logic [63:0] k;
    logic        m;
    x = d;
    for (int i = 0; i < 3; i++) begin
      if (i == 1)      k = k2;
      else if (i == 0) k = mode ? k3 : k1;
      else             k = mode ? k1 : k3;
      m = (i == 1) ? ~mode : mode;
      if (i < n) exp_core_q.push_back({m, ver, k, x});
      x = core_fn(m, k, x);
    end
    fin = x;
  endtask

  task automatic scramble_payload();
    bus.req_data_in   = {$urandom, $urandom};
    bus.req_key1_in   = {$urandom, $urandom};
    bus.req_key2_in   = {$urandom, $urandom};
    bus.req_key3_in   = {$urandom, $urandom};
    bus.req_mode_in   = 1'($urandom_range(0, 1));
    bus.req_verify_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_req(input logic mode, input logic [63:0] d, k1, k2, k3, input logic ver,
                          output bit ok);
    @(negedge clk);
    bus.req_data_in   = d;
    bus.req_key1_in   = k1;
    bus.req_key2_in   = k2;
    bus.req_key3_in   = k3;
    bus.req_mode_in   = mode;
    bus.req_verify_in = ver;
    bus.req_valid_in  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.req_ready_out) ok = 1'b1;
      else @(negedge clk);
    end
    chk("req_accept", 200'(ok), 200'(1));
    @(negedge clk);
    bus.req_valid_in = 1'b0;
  endtask

  task automatic do_req(input logic mode, input logic [63:0] d, k1, k2, k3, input logic ver,
                        input int nstage, input logic [1:0] exp_err, input int hold, input bit stray,
                        output logic [63:0] got_d, output logic [1:0] got_e, output int res_cyc);
    logic [63:0] fin;
    logic [65:0] exp;
    bit          ok;
    got_d   = '0;
    got_e   = '0;
    res_cyc = 0;
    push_core(mode, d, k1, k2, k3, ver, nstage, fin);
    exp_q.push_back({exp_err, (exp_err == 2'b00) ? fin : 64'd0});
    hs_cnt = 0;
    send_req(mode, d, k1, k2, k3, ver, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      scramble_payload();
      #1;
      if (bus.res_valid_out) ok = 1'b1;
    end
    chk("res_arrives", 200'(ok), 200'(1));
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    res_cyc = cyc;
    got_d   = bus.res_data_out;
    got_e   = bus.res_err_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (stray) begin
        scramble_payload();
        bus.req_valid_in = 1'b1;
      end
      #1;
      chk("done_hold", 200'({bus.res_valid_out, bus.req_ready_out, bus.res_err_out, bus.res_data_out}),
          200'({1'b1, 1'b0, got_e, got_d}));
    end
    bus.req_valid_in = 1'b0;
    bus.res_ready_in = 1'b1;
    exp = exp_q.pop_front();
    chk("res", 200'({got_e, got_d}), 200'(exp));
    @(negedge clk);
    bus.res_ready_in = 1'b0;
    #1;
    chk("done_exit", 200'({bus.res_valid_out, bus.req_ready_out, dbg_state}), 200'({1'b0, 1'b1, 2'b00}));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [63:0] gd;
    logic [1:0]  ge;
    int          rc;
    bit          ok;
    logic        m;
    logic [63:0] k1, k2, k3;

    bus.req_valid_in = 1'b0;
    bus.res_ready_in = 1'b0;
    scramble_payload();

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", out_vec(), reset_vec(1'b0));
    chk("reset_state", 200'(dbg_state), 200'(0));
    rst = 1'b0;
    #1;
    chk("after_reset_ready", out_vec(), reset_vec(1'b1));

    do_req(1'b0, KAT_PT, KAT_KEY, KAT_KEY, KAT_KEY, 1'b0, 3, 2'b00, 0, 1'b0, gd, ge, rc);
    chk("kat_encrypt", 200'({ge, gd}), 200'({2'b00, KAT_CT}));

    do_req(1'b1, KAT_CT, KAT_KEY, KAT_KEY, KAT_KEY, 1'b1, 3, 2'b00, 1, 1'b0, gd, ge, rc);
    chk("kat_decrypt", 200'({ge, gd}), 200'({2'b00, KAT_PT}));

    for (int i = 0; i < 6; i++) begin
      m  = 1'($urandom_range(0, 1));
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      k3 = {$urandom, $urandom};
      do_req(m, {$urandom, $urandom}, k1, k2, k3, 1'($urandom_range(0, 1)), 3, 2'b00,
             $urandom_range(0, 3), 1'b0, gd, ge, rc);
    end

    core_fault = 1;
    do_req(1'b0, 64'hDEADBEEF00C0FFEE, 64'h1111, 64'h2222, 64'h3333, 1'b1, 2, 2'b01, 0, 1'b0, gd, ge, rc);
    chk("err_hs_count", 200'(hs_cnt), 200'(2));
    chk("err_result", 200'({ge, gd}), 200'({2'b01, 64'd0}));

    core_fault = 2;
    do_req(1'b1, 64'h0F0F0F0F0F0F0F0F, 64'h4444, 64'h5555, 64'h6666, 1'b0, 1, 2'b10, 0, 1'b0, gd, ge, rc);
    chk("tmo_hs_count", 200'(hs_cnt), 200'(1));
    chk("tmo_latency", 200'(rc - hs0_cyc - 1), 200'(8));
    core_fault = 0;

    lat_fixed = 8;
    do_req(1'b0, 64'hA5A5A5A55A5A5A5A, 64'h7777, 64'h8888, 64'h9999, 1'b0, 3, 2'b00, 0, 1'b0, gd, ge, rc);
    chk("late_result_hs_count", 200'(hs_cnt), 200'(3));
    lat_fixed = 0;

    do_req(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'b1, 3, 2'b00, 5, 1'b1, gd, ge, rc);
    do_req(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'b0, 3, 2'b00, 0, 1'b0, gd, ge, rc);

    // Reset during the stage-1 wait, then let the core answer late.
    lat_fixed = 6;
    hs_cnt    = 0;
    push_core(1'b0, 64'h0BADF00D12345678, 64'hAAAA, 64'hBBBB, 64'hCCCC, 1'b1, 2, gd);
    send_req(1'b0, 64'h0BADF00D12345678, 64'hAAAA, 64'hBBBB, 64'hCCCC, 1'b1, ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (hs_cnt == 2) ok = 1'b1;
    end
    chk("stage1_reached", 200'(ok), 200'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_reset_outputs", out_vec(), reset_vec(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_quiet", out_vec(), reset_vec(1'b1));
    end
    lat_fixed = 0;
    do_req(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'b0, 3, 2'b00, 2, 1'b0, gd, ge, rc);

    repeat (5) @(negedge clk);
    chk("result_queue_drained", 200'(exp_q.size()), 200'(0));
    chk("core_queue_drained", 200'(exp_core_q.size()), 200'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdes_ctrl.md
TDES_CTRL -- requirements
Module: tdes_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, sets the maximum number of cycles per stage spent waiting for a core result before aborting; legal range 2..65535.
REQ-002 clk_in  input  1  Single clock; all logic rising-edge.
REQ-003 rst_in  input  1  Reset, synchronous, active-high.
REQ-004 req_valid_in  input  1 / req_ready_out  output  1  Upstream request handshake; a transfer occurs when both are high on a clock edge.
REQ-005 req_data_in  input  64 / req_key1_in, req_key2_in, req_key3_in  input  64 each / req_mode_in  input  1 (0=encrypt, 1=decrypt) / req_verify_in  input  1  Request payload, sampled only on a transfer.
REQ-006 core_data_out, core_key_out  output  64 / core_mode_out, core_verify_out, core_valid_out  output  1  Drive the single-DES core's data, key, mode, verify and in-valid inputs.
REQ-007 core_result_in  input  64 / core_result_valid_in, core_ready_in, core_err_in  input  1  Core output, out-valid, ready and error.
REQ-008 res_data_out  output  64 / res_err_out  output  2 (00 ok, 01 core error, 10 timeout) / res_valid_out  output  1 / res_ready_in  input  1  Result handshake.

Function
REQ-009 FSM states: IDLE, ISSUE, WAIT, DONE; a 2-bit stage counter (0..2) qualifies ISSUE and WAIT.
REQ-010 IDLE: req_ready_out=1; on a transfer, latch the payload, set stage=0, and go to ISSUE; req_ready_out=0 in all other states.
REQ-011 Stage order for encrypt (mode 0) is E(K1), D(K2), E(K3); for decrypt (mode 1) it is D(K3), E(K2), D(K1).
REQ-012 Core mode encoding: core_mode_out=0 means encrypt and 1 means decrypt; core_verify_out equals the latched verify bit in every stage.
REQ-013 Stage 0 data is the latched req_data_in; stages 1 and 2 use the previous stage's core_result_in, registered into an internal block register.
REQ-014 ISSUE: core_valid_out=1 with stable data, key and mode; once core_valid_out and core_ready_in are both high on an edge, go to WAIT, clear the timeout counter, and drop core_valid_out on the next cycle.
REQ-015 WAIT: core_valid_out=0; the timeout counter increments every cycle.
REQ-016 WAIT, core_result_valid_in=1 and core_err_in=0: store core_result_in; if stage<2, increment stage and go to ISSUE; if stage=2, load res_data_out, set res_err_out=00 and go to DONE.
REQ-017 WAIT, core_result_valid_in=1 and core_err_in=1: go to DONE with res_err_out=01 and res_data_out=0, skipping any remaining stages.
REQ-018 WAIT, counter reaches TIMEOUT_CYCLES-1 without a result: go to DONE with res_err_out=10 and res_data_out=0; if a valid result arrives on that same cycle, the result wins.
REQ-019 A core_result_valid_in outside WAIT is ignored.
REQ-020 DONE: res_valid_out=1 with data and error stable until res_ready_in=1, then go to IDLE; res_valid_out falls on the next cycle.
REQ-021 Minimum request-to-result latency is 3*(1+core latency)+1 cycles; there are no back-to-back requests, and a new request is accepted only from IDLE.
REQ-022 Payload inputs changing while not in IDLE have no effect.

Reset
REQ-023 While rst_in=1 at an edge: state=IDLE, stage=0, timeout counter=0, and req_ready_out=0 for that cycle, rising to 1 in the first cycle after reset deasserts.
REQ-024 Reset values: core_valid_out=0, core_data_out=0, core_key_out=0, core_mode_out=0, core_verify_out=0, res_valid_out=0, res_data_out=0, res_err_out=00.
REQ-025 Reset mid-operation abandons the transaction with no result emitted; a core result arriving after reset is ignored under REQ-019.

Verification
REQ-026 Encrypt with K1=K2=K3=0x133457799BBCDFF1 and data 0x0123456789ABCDEF against a reference core -> res_data_out=0x85E813540F0AB405 and res_err_out=00 (EDE with equal keys reduces to single DES).
REQ-027 Decrypt of 0x85E813540F0AB405 with the same keys -> 0x0123456789ABCDEF; core_mode_out sequence 1,0,1 and key order K3,K2,K1 observed at the core port.
REQ-028 Core asserts core_err_in with the stage-1 result -> exactly two core handshakes occur, then res_err_out=01, res_data_out=0 and res_valid_out=1.
REQ-029 Core never returns a result with TIMEOUT_CYCLES=8 -> 8 cycles after the stage-0 handshake res_err_out=10; a variant delivers the result exactly on the 8th cycle -> processing continues to stage 1.
REQ-030 Hold res_ready_in=0 for 5 cycles in DONE -> outputs are stable, req_ready_out=0 and new req_valid_in is ignored; on release, IDLE follows and the next request is accepted.
REQ-031 Assert rst_in during stage-1 WAIT, then deliver a late core result -> no res_valid_out and all outputs at reset values; a subsequent request completes correctly.
